// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signal bundle for hazard_control_unit.
// slave: the hazard unit (samples pipeline fields, drives controls).
// master: the pipeline (drives fields, samples controls).
interface hazard_control_unit_if;
  logic [3:0]  ID_Rn, ID_Rm, ID_Rd;
  logic        ID_uses_Rn, ID_uses_Rm, ID_uses_Rd;
  logic        ID_branch_taken;
  logic [3:0]  EX_Rd, MEM_Rd, WB_Rd;
  logic        EX_RF_enable, MEM_RF_enable, WB_RF_enable;
  logic        EX_load_instr;
  logic        PC_enable;
  logic        IF_ID_enable;
  logic        IF_ID_flush;
  logic        NOP_select;
  logic [1:0]  fwd_A, fwd_B, fwd_D;
  logic [15:0] stall_count, flush_count;

  modport slave (
    input  ID_Rn, ID_Rm, ID_Rd, ID_uses_Rn, ID_uses_Rm, ID_uses_Rd,
    input  ID_branch_taken, EX_Rd, MEM_Rd, WB_Rd,
    input  EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr,
    output PC_enable, IF_ID_enable, IF_ID_flush, NOP_select,
    output fwd_A, fwd_B, fwd_D, stall_count, flush_count
  );

  modport master (
    output ID_Rn, ID_Rm, ID_Rd, ID_uses_Rn, ID_uses_Rm, ID_uses_Rd,
    output ID_branch_taken, EX_Rd, MEM_Rd, WB_Rd,
    output EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr,
    input  PC_enable, IF_ID_enable, IF_ID_flush, NOP_select,
    input  fwd_A, fwd_B, fwd_D, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard/sequencing controller for the 5-stage ARM pipeline: post-reset
// warm-up, single-cycle load-use stall, branch flush and operand forwarding.
// Optional macro HAZARD_PERF_CNT_EN enables saturating stall/flush counters;
// without it stall_count/flush_count are tied to zero.
module hazard_control_unit #(
  parameter int unsigned WARMUP_CYCLES = 3
) (
  input logic               Clk,
  input logic               Reset,
  hazard_control_unit_if.slave hz
);

  typedef enum logic [1:0] {WARMUP, RUN, STALL} state_e;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] warm_cnt_q, warm_cnt_d;
  logic        load_use;
  logic        pc_en, ifid_en, nop_sel, ifid_flush;
  logic        enter_stall;

  // Forward select for one source operand; EX is skipped for loads.
  function automatic logic [1:0] fwd_sel(
    input logic       uses,
    input logic [3:0] r,
    input logic       ex_ok,
    input logic [3:0] ex_rd,
    input logic       mem_ok,
    input logic [3:0] mem_rd,
    input logic       wb_ok,
    input logic [3:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && r != 4'd15) begin
      if (ex_ok && ex_rd == r)        sel = 2'b01;
      else if (mem_ok && mem_rd == r) sel = 2'b10;
      else if (wb_ok && wb_rd == r)   sel = 2'b11;
    end
    return sel;
  endfunction

  // Load-use detection against the destination of the load in EX.
  always_comb begin
    load_use = hz.EX_load_instr & hz.EX_RF_enable &
               ((hz.ID_uses_Rn & (hz.ID_Rn == hz.EX_Rd)) |
                (hz.ID_uses_Rm & (hz.ID_Rm == hz.EX_Rd)) |
                (hz.ID_uses_Rd & (hz.ID_Rd == hz.EX_Rd)));
  end

  // State and warm-up counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= WARMUP;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Next-state and Mealy control outputs.
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    nop_sel     = 1'b0;
    ifid_flush  = 1'b0;
    enter_stall = 1'b0;
    case (state_q)
      WARMUP: begin
        warm_cnt_d = warm_cnt_q + 16'd1;
        if (warm_cnt_q == WARM_LAST) state_d = RUN;
      end
      RUN: begin
        if (load_use) begin
          // Stall beats a taken branch; the branch flushes next cycle.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          enter_stall = 1'b1;
          state_d     = STALL;
        end else begin
          nop_sel    = 1'b1;
          ifid_flush = hz.ID_branch_taken;
        end
      end
      STALL: begin
        nop_sel    = 1'b1;
        ifid_flush = hz.ID_branch_taken;
        state_d    = RUN;
      end
      default: state_d = WARMUP;
    endcase
  end

  assign hz.PC_enable    = pc_en;
  assign hz.IF_ID_enable = ifid_en;
  assign hz.NOP_select   = nop_sel;
  assign hz.IF_ID_flush  = ifid_flush;

  assign hz.fwd_A = fwd_sel(hz.ID_uses_Rn, hz.ID_Rn,
                            hz.EX_RF_enable & ~hz.EX_load_instr, hz.EX_Rd,
                            hz.MEM_RF_enable, hz.MEM_Rd, hz.WB_RF_enable, hz.WB_Rd);
  assign hz.fwd_B = fwd_sel(hz.ID_uses_Rm, hz.ID_Rm,
                            hz.EX_RF_enable & ~hz.EX_load_instr, hz.EX_Rd,
                            hz.MEM_RF_enable, hz.MEM_Rd, hz.WB_RF_enable, hz.WB_Rd);
  assign hz.fwd_D = fwd_sel(hz.ID_uses_Rd, hz.ID_Rd,
                            hz.EX_RF_enable & ~hz.EX_load_instr, hz.EX_Rd,
                            hz.MEM_RF_enable, hz.MEM_Rd, hz.WB_RF_enable, hz.WB_Rd);

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (enter_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ifid_flush && flush_cnt_q != '1)  flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
`else
  logic unused_ok;
  assign unused_ok      = enter_stall;
  assign hz.stall_count = '0;
  assign hz.flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios followed
// by randomized traffic compared against a cycle-count based reference model.
module tb_hazard_control_unit;

  localparam int unsigned WARM = 3;

  logic Clk;
  logic Reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: cycles since reset and whether last cycle stalled.
  int unsigned m_cycles   = 0;
  bit          m_prev_stl = 0;
  bit          m_valid    = 0;
  logic [15:0] m_stall_cnt = '0;
  logic [15:0] m_flush_cnt = '0;

  hazard_control_unit_if hz();

  hazard_control_unit #(.WARMUP_CYCLES(WARM)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .hz   (hz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input bit uses, input logic [3:0] r);
    logic [3:0] rd [3];
    bit         en [3];
    rd[0] = hz.EX_Rd;  en[0] = hz.EX_RF_enable && !hz.EX_load_instr;
    rd[1] = hz.MEM_Rd; en[1] = hz.MEM_RF_enable;
    rd[2] = hz.WB_Rd;  en[2] = hz.WB_RF_enable;
    if (!uses || r == 4'd15) return 2'b00;
    for (int i = 0; i < 3; i++)
      if (en[i] && rd[i] == r) return 2'(i + 1);
    return 2'b00;
  endfunction

  task automatic quiet();
    hz.ID_Rn = 0; hz.ID_Rm = 0; hz.ID_Rd = 0;
    hz.ID_uses_Rn = 0; hz.ID_uses_Rm = 0; hz.ID_uses_Rd = 0;
    hz.ID_branch_taken = 0;
    hz.EX_Rd = 0; hz.MEM_Rd = 0; hz.WB_Rd = 0;
    hz.EX_RF_enable = 0; hz.MEM_RF_enable = 0; hz.WB_RF_enable = 0;
    hz.EX_load_instr = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  task automatic randomize_inputs();
    hz.ID_Rn = rnd_reg(); hz.ID_Rm = rnd_reg(); hz.ID_Rd = rnd_reg();
    hz.ID_uses_Rn = 1'($urandom); hz.ID_uses_Rm = 1'($urandom); hz.ID_uses_Rd = 1'($urandom);
    hz.ID_branch_taken = ($urandom_range(0, 3) == 0);
    hz.EX_Rd = rnd_reg(); hz.MEM_Rd = rnd_reg(); hz.WB_Rd = rnd_reg();
    hz.EX_RF_enable = 1'($urandom); hz.MEM_RF_enable = 1'($urandom);
    hz.WB_RF_enable = 1'($urandom); hz.EX_load_instr = 1'($urandom);
    Reset = ($urandom_range(0, 59) == 0);
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, advances one edge.
  task automatic run_cycle();
    bit warm, hazard, stall, flush;
    logic [15:0] exp_sc, exp_fc;
    #2;
    warm   = (m_cycles < WARM);
    hazard = hz.EX_load_instr && hz.EX_RF_enable &&
             ((hz.ID_uses_Rn && hz.ID_Rn == hz.EX_Rd) ||
              (hz.ID_uses_Rm && hz.ID_Rm == hz.EX_Rd) ||
              (hz.ID_uses_Rd && hz.ID_Rd == hz.EX_Rd));
    stall  = !warm && !m_prev_stl && hazard;
    flush  = !warm && !stall && hz.ID_branch_taken;
`ifdef HAZARD_PERF_CNT_EN
    exp_sc = m_stall_cnt; exp_fc = m_flush_cnt;
`else
    exp_sc = '0; exp_fc = '0;
`endif
    if (m_valid) begin
      check("PC_enable",    32'(hz.PC_enable),    32'(!stall));
      check("IF_ID_enable", 32'(hz.IF_ID_enable), 32'(!stall));
      check("NOP_select",   32'(hz.NOP_select),   32'(!warm && !stall));
      check("IF_ID_flush",  32'(hz.IF_ID_flush),  32'(flush));
      check("fwd_A", 32'(hz.fwd_A), 32'(fwd_ref(hz.ID_uses_Rn, hz.ID_Rn)));
      check("fwd_B", 32'(hz.fwd_B), 32'(fwd_ref(hz.ID_uses_Rm, hz.ID_Rm)));
      check("fwd_D", 32'(hz.fwd_D), 32'(fwd_ref(hz.ID_uses_Rd, hz.ID_Rd)));
      check("stall_count", 32'(hz.stall_count), 32'(exp_sc));
      check("flush_count", 32'(hz.flush_count), 32'(exp_fc));
    end
    @(posedge Clk);
    if (Reset) begin
      m_valid = 1; m_cycles = 0; m_prev_stl = 0;
      m_stall_cnt = '0; m_flush_cnt = '0;
    end else begin
      if (m_cycles < 1000) m_cycles++;
      m_prev_stl = stall;
      if (stall && m_stall_cnt != 16'hFFFF) m_stall_cnt++;
      if (flush && m_flush_cnt != 16'hFFFF) m_flush_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    Reset = 1; quiet();
    run_cycle(); run_cycle();
    Reset = 0;
  endtask

  initial begin
    Reset = 1; quiet();
    @(posedge Clk); #1;

    // Reset and warm-up: NOP injected for exactly WARM cycles.
    do_reset();
    #1 check("rst_pc_en", 32'(hz.PC_enable), 32'd1);
    for (int unsigned i = 0; i < WARM; i++) begin
      #1 check("warm_nop", 32'(hz.NOP_select), 32'd0);
      #0 run_cycle();
    end
    #1 check("run_nop", 32'(hz.NOP_select), 32'd1);
    run_cycle();

    // Load-use on Rn: stall now, then one STALL cycle forwarding from MEM.
    quiet();
    hz.EX_load_instr = 1; hz.EX_RF_enable = 1; hz.EX_Rd = 4'd1;
    hz.ID_Rn = 4'd1; hz.ID_uses_Rn = 1;
    #1 check("lu_pc_en", 32'(hz.PC_enable), 32'd0);
    check("lu_nop", 32'(hz.NOP_select), 32'd0);
    run_cycle();
    hz.EX_load_instr = 0; hz.EX_RF_enable = 0; hz.EX_Rd = 4'd0;
    hz.MEM_Rd = 4'd1; hz.MEM_RF_enable = 1;
    #1 check("stl_fwdA", 32'(hz.fwd_A), 32'd2);
`ifdef HAZARD_PERF_CNT_EN
    check("stl_cnt", 32'(hz.stall_count), 32'd1);
`endif
    run_cycle();

    // Forwarding priority MEM > WB, and R15 never forwarded.
    quiet();
    hz.MEM_Rd = 4'd2; hz.WB_Rd = 4'd2; hz.MEM_RF_enable = 1; hz.WB_RF_enable = 1;
    hz.ID_Rm = 4'd2; hz.ID_uses_Rm = 1;
    #1 check("fwdB_mem", 32'(hz.fwd_B), 32'd2);
    hz.MEM_RF_enable = 0;
    #1 check("fwdB_wb", 32'(hz.fwd_B), 32'd3);
    hz.ID_Rm = 4'd15; hz.WB_Rd = 4'd15;
    #1 check("fwdB_r15", 32'(hz.fwd_B), 32'd0);
    run_cycle();

    // Taken branch without hazard.
    quiet(); hz.ID_branch_taken = 1;
    #1 check("br_flush", 32'(hz.IF_ID_flush), 32'd1);
    run_cycle();

    // Hazard plus branch: stall wins, branch flushes in the STALL cycle.
    hz.EX_load_instr = 1; hz.EX_RF_enable = 1; hz.EX_Rd = 4'd5;
    hz.ID_Rd = 4'd5; hz.ID_uses_Rd = 1;
    #1 check("hb_flush0", 32'(hz.IF_ID_flush), 32'd0);
    check("hb_pc0", 32'(hz.PC_enable), 32'd0);
    run_cycle();
    #1 check("hb_flush1", 32'(hz.IF_ID_flush), 32'd1);
    run_cycle();

    // Reset during STALL returns to warm-up.
    quiet();
    hz.EX_load_instr = 1; hz.EX_RF_enable = 1; hz.EX_Rd = 4'd3;
    hz.ID_Rm = 4'd3; hz.ID_uses_Rm = 1;
    run_cycle();
    Reset = 1;
    run_cycle();
    Reset = 0;
    #1 check("rst_stl_nop", 32'(hz.NOP_select), 32'd0);
    run_cycle();

    // Randomized traffic.
    for (int unsigned c = 0; c < 3000; c++) begin
      randomize_inputs();
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
